// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - ID stage handshake, write-back and ID/EX output bundle
interface decode_stage_if #(
    parameter int DATA_W = 8
);
    logic              flush;
    logic              ex_stall;
    logic              in_valid;
    logic [15:0]       instruction;
    logic              in_ready;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic [3:0]        out_opcode;
    logic [2:0]        out_rs1;
    logic [2:0]        out_rs2;
    logic [2:0]        out_rd;
    logic              out_rd_we;
    logic [DATA_W-1:0] out_rdata1;
    logic [DATA_W-1:0] out_rdata2;
    logic [DATA_W-1:0] out_imm;
    logic              hazard_stall;

    modport master (
        output flush, ex_stall, in_valid, instruction, wb_en, wb_reg, wb_data,
        input  in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
               out_rd_we, out_rdata1, out_rdata2, out_imm, hazard_stall
    );

    modport slave (
        input  flush, ex_stall, in_valid, instruction, wb_en, wb_reg, wb_data,
        output in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
               out_rd_we, out_rdata1, out_rdata2, out_imm, hazard_stall
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered ID stage: decode, regfile with bypass, load-use bubble, ID/EX register
module decode_stage #(
    parameter int         DATA_W    = 8,
    parameter bit         WB_BYPASS = 1'b1,
    parameter logic [3:0] LOAD_OP   = 4'b1001
) (
    input logic            clk,
    input logic            reset,
    decode_stage_if.slave  bus
);
    logic [15:0]       instr;
    logic [3:0]        op;
    logic [2:0]        rs1, rs2, rd;
    logic              use_rs1, use_rs2, rd_we;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              hazard;

    logic [DATA_W-1:0] rf [8];

    logic              q_valid;
    logic [3:0]        q_opcode;
    logic [2:0]        q_rs1, q_rs2, q_rd;
    logic              q_rd_we;
    logic [DATA_W-1:0] q_rdata1, q_rdata2, q_imm;

    // Field decode; an empty slot decodes as the E-opcode NOP so it carries no register uses.
    always_comb begin
        instr   = bus.in_valid ? bus.instruction : 16'hE000;
        op      = instr[15:12];
        rs1     = 3'd0;
        rs2     = 3'd0;
        rd      = 3'd0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        rd_we   = 1'b0;
        imm     = '0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                rs1 = instr[11:9]; rs2 = instr[8:6]; rd = instr[5:3];
                use_rs1 = 1'b1; use_rs2 = 1'b1; rd_we = 1'b1;
            end
            4'h6, 4'h7, 4'h9: begin
                rs1 = instr[8:6]; rd = instr[11:9];
                use_rs1 = 1'b1; rd_we = 1'b1;
                imm = DATA_W'($signed(instr[5:0]));
            end
            4'h8: begin
                rs1 = instr[8:6]; rs2 = instr[11:9];
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = DATA_W'($signed(instr[5:0]));
            end
            4'hA: begin
                rd = instr[11:9]; rd_we = 1'b1;
                imm = DATA_W'($signed(instr[7:0]));
            end
            4'hB, 4'hC: begin
                rs1 = instr[11:9]; rs2 = instr[8:6];
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = DATA_W'($signed(instr[5:0]));
            end
            default: ;
        endcase
    end

    // Asynchronous operand read, optionally forwarding the write-back landing this same edge.
    always_comb begin
        rdata1 = rf[rs1];
        rdata2 = rf[rs2];
        if (WB_BYPASS && bus.wb_en && bus.wb_reg == rs1) rdata1 = bus.wb_data;
        if (WB_BYPASS && bus.wb_en && bus.wb_reg == rs2) rdata2 = bus.wb_data;
    end

    // Load-use detection against the instruction now sitting in ID/EX.
    always_comb begin
        hazard = bus.in_valid & q_valid & (q_opcode == LOAD_OP) & q_rd_we &
                 ((use_rs1 & (rs1 == q_rd)) | (use_rs2 & (rs2 == q_rd)));
    end

    // Reset outranks everything, so nothing is consumed or bubbled while it is held.
    assign bus.in_ready     = ~reset & ~bus.ex_stall & ~hazard & ~bus.flush;
    assign bus.hazard_stall = ~reset & hazard & ~bus.ex_stall & ~bus.flush;

    // Register file write; reset clears every entry and ignores a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (bus.wb_en) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    // ID/EX register: reset/flush clear, stall holds, hazard bubbles, otherwise latch decode.
    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.ex_stall && hazard)) begin
            q_valid  <= 1'b0;
            q_opcode <= 4'd0;
            q_rs1    <= 3'd0;
            q_rs2    <= 3'd0;
            q_rd     <= 3'd0;
            q_rd_we  <= 1'b0;
            q_rdata1 <= '0;
            q_rdata2 <= '0;
            q_imm    <= '0;
        end else if (!bus.ex_stall) begin
            q_valid  <= bus.in_valid;
            q_opcode <= op;
            q_rs1    <= rs1;
            q_rs2    <= rs2;
            q_rd     <= rd;
            q_rd_we  <= rd_we;
            q_rdata1 <= rdata1;
            q_rdata2 <= rdata2;
            q_imm    <= imm;
        end
    end

    assign bus.out_valid  = q_valid;
    assign bus.out_opcode = q_opcode;
    assign bus.out_rs1    = q_rs1;
    assign bus.out_rs2    = q_rs2;
    assign bus.out_rd     = q_rd;
    assign bus.out_rd_we  = q_rd_we;
    assign bus.out_rdata1 = q_rdata1;
    assign bus.out_rdata2 = q_rdata2;
    assign bus.out_imm    = q_imm;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage with and without write-back bypass
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(8)) bus_a ();
    decode_stage_if #(.DATA_W(8)) bus_b ();

    decode_stage #(.DATA_W(8), .WB_BYPASS(1'b1), .LOAD_OP(4'b1001)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    decode_stage #(.DATA_W(8), .WB_BYPASS(1'b0), .LOAD_OP(4'b1001)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    assign bus_b.flush       = bus_a.flush;
    assign bus_b.ex_stall    = bus_a.ex_stall;
    assign bus_b.in_valid    = bus_a.in_valid;
    assign bus_b.instruction = bus_a.instruction;
    assign bus_b.wb_en       = bus_a.wb_en;
    assign bus_b.wb_reg      = bus_a.wb_reg;
    assign bus_b.wb_data     = bus_a.wb_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins);
        bus_a.in_valid    = v;
        bus_a.instruction = ins;
    endtask

    task automatic wb(input logic en, input logic [2:0] r, input logic [7:0] d);
        bus_a.wb_en   = en;
        bus_a.wb_reg  = r;
        bus_a.wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] idx;
        reset          = 1'b1;
        bus_a.flush    = 1'b0;
        bus_a.ex_stall = 1'b0;
        drive(1'b1, 16'h04D0);
        wb(1'b1, 3'd3, 8'hFF);
        step();
        step();
        check_eq("rst_valid",  bus_a.out_valid,  0);
        check_eq("rst_opcode", bus_a.out_opcode, 0);
        check_eq("rst_rd",     bus_a.out_rd,     0);
        check_eq("rst_rdata1", bus_a.out_rdata1, 0);
        check_eq("rst_imm",    bus_a.out_imm,    0);

        reset = 1'b0;
        wb(1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            drive(1'b1, {4'h0, idx, idx, 3'b000});
            step();
            check_eq($sformatf("rf_clear_r%0d", i), {bus_a.out_rdata1, bus_a.out_rdata2}, 0);
        end

        drive(1'b0, 16'h0000);
        wb(1'b1, 3'd2, 8'h05);
        step();
        wb(1'b1, 3'd3, 8'h0A);
        step();
        wb(1'b0, 3'd0, 8'h00);
        drive(1'b1, 16'h04D0);
        step();
        check_eq("alu_valid",  bus_a.out_valid,  1);
        check_eq("alu_rdata1", bus_a.out_rdata1, 8'h05);
        check_eq("alu_rdata2", bus_a.out_rdata2, 8'h0A);
        check_eq("alu_rd",     bus_a.out_rd,     2);
        check_eq("alu_rd_we",  bus_a.out_rd_we,  1);

        drive(1'b1, 16'h6B03);
        wb(1'b1, 3'd4, 8'h77);
        step();
        wb(1'b0, 3'd0, 8'h00);
        check_eq("byp_on",     bus_a.out_rdata1, 8'h77);
        check_eq("byp_off",    bus_b.out_rdata1, 8'h00);
        check_eq("op6_rs1",    bus_a.out_rs1,    4);
        check_eq("op6_rd",     bus_a.out_rd,     5);
        check_eq("op6_imm",    bus_a.out_imm,    8'h03);

        drive(1'b1, 16'h6B3E);
        step();
        check_eq("sext_imm",   bus_a.out_imm,    8'hFE);
        check_eq("r4_written", bus_b.out_rdata1, 8'h77);

        drive(1'b1, 16'h9240);
        step();
        check_eq("ld_opcode",  bus_a.out_opcode, 4'h9);
        check_eq("ld_rd",      bus_a.out_rd,     1);
        drive(1'b1, 16'h0280);
        #1;
        check_eq("hz_stall",   bus_a.hazard_stall, 1);
        check_eq("hz_ready",   bus_a.in_ready,     0);
        step();
        check_eq("hz_bubble",  bus_a.out_valid,    0);
        check_eq("hz_bub_op",  bus_a.out_opcode,   0);
        check_eq("hz_clear",   bus_a.hazard_stall, 0);
        check_eq("hz_ready1",  bus_a.in_ready,     1);
        step();
        check_eq("dep_valid",  bus_a.out_valid,    1);
        check_eq("dep_rs1",    bus_a.out_rs1,      1);
        check_eq("dep_rs2",    bus_a.out_rs2,      2);

        drive(1'b1, 16'hAE80);
        bus_a.flush = 1'b1;
        #1;
        check_eq("fl_ready",   bus_a.in_ready,   0);
        step();
        bus_a.flush = 1'b0;
        check_eq("fl_valid",   bus_a.out_valid,  0);
        check_eq("fl_opcode",  bus_a.out_opcode, 0);
        check_eq("fl_rs1",     bus_a.out_rs1,    0);

        drive(1'b1, 16'h04D0);
        step();
        drive(1'b1, 16'h2250);
        bus_a.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("st_ready%0d", i), bus_a.in_ready, 0);
            step();
            check_eq($sformatf("st_hold%0d", i),
                     {bus_a.out_valid, bus_a.out_opcode, bus_a.out_rd, bus_a.out_rdata1},
                     {1'b1, 4'h0, 3'd2, 8'h05});
        end
        bus_a.ex_stall = 1'b0;
        step();
        check_eq("st_move_op", bus_a.out_opcode, 4'h2);
        check_eq("st_move_rd", bus_a.out_rd,     2);

        drive(1'b1, 16'hAE80);
        step();
        check_eq("opa_fields", {bus_a.out_opcode, bus_a.out_rd, bus_a.out_rd_we, bus_a.out_rs1},
                 {4'hA, 3'd7, 1'b1, 3'd0});
        check_eq("opa_imm",    bus_a.out_imm, 8'h80);

        bus_a.ex_stall = 1'b1;
        drive(1'b1, 16'h04D0);
        reset = 1'b1;
        #1;
        check_eq("rst_st_rdy", bus_a.in_ready, 0);
        step();
        reset = 1'b0;
        bus_a.ex_stall = 1'b0;
        drive(1'b0, 16'h0000);
        check_eq("rst_st_val", bus_a.out_valid, 0);
        step();
        check_eq("idle_valid", bus_a.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
